// File: rtl/demux_1to4_stream_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package demux_1to4_stream_pkg;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned SEL_W   = 2;

    // Bit offset of output slice idx in a flat bus of w-bit slices.
    function automatic int unsigned slice_off(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output slot: a single-entry register with valid/ready and a delivered-beat counter.
module demux_out_slot #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              flush,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  m_count
);

    logic drain_c;

    // A beat leaves the slot when it is held and downstream accepts it.
    assign drain_c = m_valid & m_ready;

    // Delivered-beat counter; flush does not suppress a drain that happens on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= '0;
        end else if (drain_c) begin
            m_count <= m_count + CNT_W'(1);
        end
    end

    // Full flag and payload: flush wins, then load (also covers drain+reload), then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
        end else if (drain_c) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with independent per-output slots.
module demux_1to4_stream
    import demux_1to4_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic [SEL_W-1:0]          s_sel,
    output logic [NUM_OUT-1:0]        m_valid,
    input  logic [NUM_OUT-1:0]        m_ready,
    output logic [NUM_OUT*DATA_W-1:0] m_data,
    output logic [NUM_OUT*CNT_W-1:0]  m_count
);

    logic [NUM_OUT-1:0] load;

    // Only the addressed slot gates acceptance, so a stalled output never blocks the others.
    assign s_ready = rst_n & ~flush & (~m_valid[s_sel] | m_ready[s_sel]);

    // Decode the select into one load strobe for the accepted beat.
    always_comb begin
        load = '0;
        if (s_valid && s_ready) begin
            load[s_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        demux_out_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[i]),
            .load_data (s_data),
            .flush     (flush),
            .m_ready   (m_ready[i]),
            .m_valid   (m_valid[i]),
            .m_data    (m_data[slice_off(i, DATA_W) +: DATA_W]),
            .m_count   (m_count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: directed table, corner sequences, random traffic.
module tb_demux_1to4_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [1:0]    s_sel;
    logic [3:0]    m_valid;
    logic [3:0]    m_ready;
    logic [4*DW-1:0] m_data;
    logic [4*CW-1:0] m_count;

    demux_1to4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: per-output FIFO of beats in flight, last payload, delivered count.
    logic [7:0] q [4][$];
    logic [7:0] last_d [4];
    int         cnt [4];
    logic       last_acc;
    logic       ready_seen;

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] rdy;
        logic       fl;
        logic       exp_ready;
        logic [3:0] exp_valid;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            last_d[i] = '0;
            cnt[i] = 0;
        end
    endfunction

    task automatic check_outputs();
        logic [3:0]    ev;
        logic [4*DW-1:0] ed;
        logic [4*CW-1:0] ec;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (q[i].size() != 0);
            ed[i*DW +: DW] = last_d[i];
            ec[i*CW +: CW] = CW'(cnt[i]);
        end
        check("m_valid", 64'(m_valid), 64'(ev));
        check("m_data", 64'(m_data), 64'(ed));
        check("m_count", 64'(m_count), 64'(ec));
    endtask

    // Drive one cycle, check s_ready before the edge and registered outputs after it.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic [3:0] rdy, input logic fl);
        logic er;
        logic acc;
        @(negedge clk);
        s_valid = v; s_sel = sel; s_data = d; m_ready = rdy; flush = fl;
        #1;
        er = !fl && (q[sel].size() == 0 || rdy[sel]);
        ready_seen = s_ready;
        check("s_ready", 64'(s_ready), 64'(er));
        acc = v && er;
        last_acc = acc;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() != 0 && rdy[i]) begin
                void'(q[i].pop_front());
                cnt[i] = (cnt[i] + 1) % (1 << CW);
            end
        end
        if (fl) begin
            for (int i = 0; i < 4; i++) begin
                q[i].delete();
                last_d[i] = '0;
            end
        end
        if (acc) begin
            q[sel].push_back(d);
            last_d[sel] = d;
        end
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; flush = 1'b0; m_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check("reset_state", 64'({m_valid, m_data, m_count}), 64'(0));
    endtask

    vec_t vecs [10];

    initial begin
        logic       hv;
        logic [1:0] hs;
        logic [7:0] hd;
        logic [3:0] cnt_snapshot;

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_sel = '0; m_ready = '0;
        last_acc = 1'b1; ready_seen = 1'b0;
        model_reset();

        // Stream A0..A3 to outputs 0..3, then the stalled-output-2 sequence.
        vecs[0] = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b0, 1'b1, 4'b0001};
        vecs[1] = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b0, 1'b1, 4'b0010};
        vecs[2] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b0, 1'b1, 4'b0100};
        vecs[3] = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b0, 1'b1, 4'b1000};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'b0000};
        vecs[5] = '{1'b1, 2'd2, 8'h11, 4'hB, 1'b0, 1'b1, 4'b0100};
        vecs[6] = '{1'b1, 2'd2, 8'h22, 4'hB, 1'b0, 1'b0, 4'b0100};
        vecs[7] = '{1'b1, 2'd1, 8'h33, 4'hB, 1'b0, 1'b1, 4'b0110};
        vecs[8] = '{1'b1, 2'd2, 8'h22, 4'hF, 1'b0, 1'b1, 4'b0100};
        vecs[9] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'b0000};

        do_reset();

        for (int k = 0; k < 10; k++) begin
            cycle(vecs[k].v, vecs[k].sel, vecs[k].d, vecs[k].rdy, vecs[k].fl);
            check($sformatf("vec%0d_ready", k), 64'(ready_seen), 64'(vecs[k].exp_ready));
            check($sformatf("vec%0d_valid", k), 64'(m_valid), 64'(vecs[k].exp_valid));
            if (k == 4) check("count_after_stream", 64'(m_count), 64'({8'd1, 8'd1, 8'd1, 8'd1}));
            if (k == 8) check("slot2_reload", 64'(m_data[2*DW +: DW]), 64'(8'h22));
        end

        // Back-to-back beats to output 3 at full rate: 1 from the stream plus 10 here.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 2'd3, 8'(8'h50 + k), 4'hF, 1'b0);
            check("b2b_ready", 64'(ready_seen), 64'(1));
            check("b2b_data", 64'(m_data[3*DW +: DW]), 64'(8'h50 + k));
        end
        cycle(1'b0, 2'd3, 8'h00, 4'hF, 1'b0);
        check("b2b_count3", 64'(m_count[3*CW +: CW]), 64'(11));

        // Random traffic with protocol-legal upstream hold and occasional flush.
        hv = 1'b0; hs = '0; hd = '0;
        for (int k = 0; k < 600; k++) begin
            if (!(hv && !last_acc)) begin
                hv = ($urandom % 4) != 0;
                hs = 2'($urandom);
                hd = 8'($urandom);
            end
            cycle(hv, hs, hd, 4'($urandom), ($urandom % 24) == 0);
        end
        hv = 1'b0;

        // Fill every slot with all outputs stalled, then flush with a valid beat present.
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 8'(8'hC0 + i), 4'h0, 1'b0);
        check("fill_valid", 64'(m_valid), 64'(4'hF));
        cycle(1'b1, 2'd1, 8'hEE, 4'h0, 1'b1);
        check("flush_ready", 64'(ready_seen), 64'(0));
        check("flush_valid", 64'(m_valid), 64'(0));
        check("flush_data", 64'(m_data), 64'(0));

        // Refill, then assert reset between edges and expect outputs to clear at once.
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 8'(8'h70 + i), 4'h0, 1'b0);
        cnt_snapshot = 4'(m_count != '0);
        check("pre_reset_full", 64'(m_valid), 64'(4'hF));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(m_valid), 64'(0));
        check("async_rst_data", 64'(m_data), 64'(0));
        check("async_rst_count", 64'(m_count), 64'(0));
        check("async_rst_ready", 64'(s_ready), 64'(0));
        if (cnt_snapshot == 4'd0) begin
            errors++;
            checks++;
            $display("FAIL pre_reset_count: got 0 expected nonzero");
        end
        do_reset();

        // 256 beats to output 0: the 8-bit counter wraps back to 0.
        for (int k = 0; k < 256; k++) cycle(1'b1, 2'd0, 8'(k), 4'h1, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 4'h1, 1'b0);
        check("wrap_count0", 64'(m_count[CW-1:0]), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
